// File: rtl/dpram_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one port of a true-dual-port RAM
// between two requesters; read data returns to the issuing requester one cycle later.
module dpram_port_arbiter #(
    parameter int AW        = 9,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_r0_valid,
    input  logic          i_r0_we,
    input  logic [AW-1:0] i_r0_addr,
    input  logic [DW-1:0] i_r0_wdata,
    output logic          o_r0_ready,
    output logic          o_r0_rvalid,
    output logic [DW-1:0] o_r0_rdata,
    input  logic          i_r1_valid,
    input  logic          i_r1_we,
    input  logic [AW-1:0] i_r1_addr,
    input  logic [DW-1:0] i_r1_wdata,
    output logic          o_r1_ready,
    output logic          o_r1_rvalid,
    output logic [DW-1:0] o_r1_rdata,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    logic       r_prio;
    logic [3:0] r_bcnt;
    logic       r_rsp_pending;
    logic       r_rsp_id;

    logic w_both;
    logic w_g0;
    logic w_g1;
    logic w_beat;
    logic w_gwe;

    // Grants are suppressed during reset so the RAM port stays quiet.
    always_comb begin
        w_both = i_r0_valid && i_r1_valid;
        w_g0   = !i_rst && i_r0_valid && (!i_r1_valid || !r_prio);
        w_g1   = !i_rst && i_r1_valid && (!i_r0_valid ||  r_prio);
        w_beat = w_g0 || w_g1;
        w_gwe  = w_g1 ? i_r1_we : (w_g0 ? i_r0_we : 1'b0);
    end

    assign o_r0_ready  = w_g0;
    assign o_r1_ready  = w_g1;
    assign o_ram_en    = w_beat;
    assign o_ram_we    = w_gwe;
    assign o_ram_addr  = w_g1 ? i_r1_addr  : i_r0_addr;
    assign o_ram_wdata = w_g1 ? i_r1_wdata : i_r0_wdata;

    // Only contended beats count toward the burst; an uncontended beat
    // makes the current user the preferred one and restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prio <= 1'b0;
            r_bcnt <= 4'd0;
        end else if (w_beat) begin
            if (w_both) begin
                if (r_bcnt == LAST_BEAT) begin
                    r_prio <= ~w_g1;
                    r_bcnt <= 4'd0;
                end else begin
                    r_bcnt <= r_bcnt + 4'd1;
                end
            end else begin
                r_prio <= w_g1;
                r_bcnt <= 4'd0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_pending <= 1'b0;
            r_rsp_id      <= 1'b0;
        end else begin
            r_rsp_pending <= w_beat && !w_gwe;
            r_rsp_id      <= w_g1;
        end
    end

    // Gating with reset drops a response whose read was in flight.
    assign o_r0_rvalid = !i_rst && r_rsp_pending && !r_rsp_id;
    assign o_r1_rvalid = !i_rst && r_rsp_pending &&  r_rsp_id;
    assign o_r0_rdata  = i_ram_rdata;
    assign o_r1_rdata  = i_ram_rdata;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench with a read-response scoreboard; DUT A uses MAX_BURST=4,
// DUT B uses MAX_BURST=1 for the alternating-write case.
module tb_dpram_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic init;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
    } rsp_t;
    rsp_t sbq[$];

    // ---------------- DUT A ----------------
    logic          a0_v, a0_we, a0_rdy, a0_rv;
    logic [AW-1:0] a0_ad;
    logic [DW-1:0] a0_wd, a0_rd;
    logic          a1_v, a1_we, a1_rdy, a1_rv;
    logic [AW-1:0] a1_ad;
    logic [DW-1:0] a1_wd, a1_rd;
    logic          a_en, a_we;
    logic [AW-1:0] a_ad;
    logic [DW-1:0] a_wd, a_rdat;
    logic [DW-1:0] mem_a [0:511];
    logic [DW-1:0] shadow_a [0:511];

    dpram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_r0_valid(a0_v), .i_r0_we(a0_we), .i_r0_addr(a0_ad), .i_r0_wdata(a0_wd),
        .o_r0_ready(a0_rdy), .o_r0_rvalid(a0_rv), .o_r0_rdata(a0_rd),
        .i_r1_valid(a1_v), .i_r1_we(a1_we), .i_r1_addr(a1_ad), .i_r1_wdata(a1_wd),
        .o_r1_ready(a1_rdy), .o_r1_rvalid(a1_rv), .o_r1_rdata(a1_rd),
        .o_ram_en(a_en), .o_ram_we(a_we), .o_ram_addr(a_ad), .o_ram_wdata(a_wd),
        .i_ram_rdata(a_rdat)
    );

    // read-first RAM, preloaded with addr[7:0]^0xA0
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 512; i++) mem_a[i] <= 8'(i) ^ 8'hA0;
        end else if (a_en) begin
            a_rdat <= mem_a[a_ad];
            if (a_we) mem_a[a_ad] <= a_wd;
        end
    end

    // ---------------- DUT B ----------------
    logic          b0_v, b0_we, b0_rdy, b0_rv;
    logic [AW-1:0] b0_ad;
    logic [DW-1:0] b0_wd, b0_rd;
    logic          b1_v, b1_we, b1_rdy, b1_rv;
    logic [AW-1:0] b1_ad;
    logic [DW-1:0] b1_wd, b1_rd;
    logic          b_en, b_we;
    logic [AW-1:0] b_ad;
    logic [DW-1:0] b_wd, b_rdat;
    logic [DW-1:0] mem_b [0:511];

    dpram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(1)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_r0_valid(b0_v), .i_r0_we(b0_we), .i_r0_addr(b0_ad), .i_r0_wdata(b0_wd),
        .o_r0_ready(b0_rdy), .o_r0_rvalid(b0_rv), .o_r0_rdata(b0_rd),
        .i_r1_valid(b1_v), .i_r1_we(b1_we), .i_r1_addr(b1_ad), .i_r1_wdata(b1_wd),
        .o_r1_ready(b1_rdy), .o_r1_rvalid(b1_rv), .o_r1_rdata(b1_rd),
        .o_ram_en(b_en), .o_ram_we(b_we), .o_ram_addr(b_ad), .o_ram_wdata(b_wd),
        .i_ram_rdata(b_rdat)
    );

    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 512; i++) mem_b[i] <= 8'h00;
        end else if (b_en) begin
            b_rdat <= mem_b[b_ad];
            if (b_we) mem_b[b_ad] <= b_wd;
        end
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (a0_rv || a1_rv) begin
            rsp_t e;
            checks++;
            if (a0_rv && a1_rv) begin
                errors++;
                $display("FAIL a_rvalid_both act=11 exp=one-hot");
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL a_rvalid_unexpected act_id=%0d exp=none", a1_rv);
            end else begin
                e = sbq.pop_front();
                if (e.id != a1_rv || (a1_rv ? a1_rd : a0_rd) != e.data) begin
                    errors++;
                    $display("FAIL a_rsp act_id=%0d act_data=%02h exp_id=%0d exp_data=%02h",
                             a1_rv, a1_rv ? a1_rd : a0_rd, e.id, e.data);
                end
            end
        end
        if (b0_rv || b1_rv) begin
            checks++;
            errors++;
            $display("FAIL b_rvalid_unexpected act=%0d%0d exp=00", b1_rv, b0_rv);
        end
    end

    // ---------------- stimulus helpers ----------------
    int g_act;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drv_a(input logic v0, input logic we0, input logic [AW-1:0] ad0,
                         input logic [DW-1:0] wd0, input logic v1, input logic we1,
                         input logic [AW-1:0] ad1, input logic [DW-1:0] wd1);
        a0_v = v0; a0_we = we0; a0_ad = ad0; a0_wd = wd0;
        a1_v = v1; a1_we = we1; a1_ad = ad1; a1_wd = wd1;
    endtask

    // expg: 0/1 = requester granted, 2 = no grant. push=0 skips the scoreboard.
    task automatic tick_a(input string nm, input int expg, input bit push = 1'b1);
        logic [AW-1:0] ad;
        logic          we;
        logic [DW-1:0] wd;
        rsp_t          e;
        @(negedge clk);
        if (a0_rdy && a1_rdy) g_act = 3;
        else g_act = a0_rdy ? 0 : (a1_rdy ? 1 : 2);
        chk({nm, "_grant"}, g_act, expg);
        chk({nm, "_en"}, int'(a_en), int'(expg != 2));
        if (expg != 2) begin
            ad = (expg == 1) ? a1_ad : a0_ad;
            we = (expg == 1) ? a1_we : a0_we;
            wd = (expg == 1) ? a1_wd : a0_wd;
            chk({nm, "_addr"}, int'(a_ad), int'(ad));
            chk({nm, "_we"}, int'(a_we), int'(we));
            if (g_act == expg) begin
                if (we) begin
                    shadow_a[ad] = wd;
                end else if (push) begin
                    e.id = (expg == 1);
                    e.data = shadow_a[ad];
                    sbq.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    int exp_c[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int exp_s[5]  = '{1, 1, 1, 1, 0};
    logic [DW-1:0] b0_data[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        int n0, n1;
        for (int i = 0; i < 512; i++) shadow_a[i] = 8'(i) ^ 8'hA0;
        rst = 1'b1; init = 1'b1;
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        b0_v = 0; b0_we = 0; b0_ad = 0; b0_wd = 0;
        b1_v = 0; b1_we = 0; b1_ad = 0; b1_wd = 0;
        @(posedge clk); #1;
        init = 1'b0;

        // reset state: both valid but nothing granted
        drv_a(1, 0, 9'h040, 0, 1, 0, 9'h080, 0);
        @(negedge clk);
        chk("rst_rvalid", int'({a1_rv, a0_rv}), 0);
        chk("rst_we", int'(a_we), 0);
        @(posedge clk); #1;
        tick_a("rst", 2);
        rst = 1'b0;

        // contention, MAX_BURST=4
        n0 = 0; n1 = 0;
        for (int k = 0; k < 10; k++) begin
            drv_a(1, 0, 9'(9'h040 + n0), 0, 1, 0, 9'(9'h080 + n1), 0);
            tick_a("cont", exp_c[k]);
            if (g_act == 0) n0++;
            if (g_act == 1) n1++;
        end

        // single read at 0x005 -> 0xA5
        drv_a(1, 0, 9'h005, 0, 0, 0, 0, 0);
        tick_a("single", 0);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        tick_a("idle", 2);

        // write then read 0x1FF by r1
        drv_a(0, 0, 0, 0, 1, 1, 9'h1FF, 8'h3C);
        tick_a("wr1ff", 1);
        drv_a(0, 0, 0, 0, 1, 0, 9'h1FF, 0);
        tick_a("rd1ff", 1);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        tick_a("idle", 2);

        // uncontended streaming r1, then contention proves prio=1 and bcnt=0
        for (int k = 0; k < 6; k++) begin
            drv_a(0, 0, 0, 0, 1, 0, 9'(9'h010 + k), 0);
            tick_a("stream", 1);
        end
        n1 = 0;
        for (int k = 0; k < 5; k++) begin
            drv_a(1, 0, 9'h0F0, 0, 1, 0, 9'(9'h016 + n1), 0);
            tick_a("post_stream", exp_s[k]);
            if (g_act == 1) n1++;
        end
        drv_a(0, 0, 0, 0, 1, 0, 9'(9'h016 + n1), 0);
        tick_a("post_stream_r1", 1);

        // prio returns to 0 after reset
        drv_a(0, 0, 0, 0, 1, 0, 9'h033, 0);
        tick_a("set_prio1", 1);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        tick_a("idle", 2);
        rst = 1'b1;
        tick_a("rst2", 2);
        rst = 1'b0;
        drv_a(1, 0, 9'h044, 0, 1, 0, 9'h055, 0);
        tick_a("prio_rst", 0);
        drv_a(0, 0, 0, 0, 1, 0, 9'h055, 0);
        tick_a("prio_rst_r1", 1);

        // reset while a read is in flight: response must be dropped
        drv_a(1, 0, 9'h007, 0, 0, 0, 0, 0);
        tick_a("inflight", 0, 1'b0);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick_a("inflight_rst", 2);
        rst = 1'b0;
        tick_a("idle", 2);
        drv_a(1, 0, 9'h008, 0, 1, 0, 9'h009, 0);
        tick_a("inflight_prio", 0);
        drv_a(0, 0, 0, 0, 1, 0, 9'h009, 0);
        tick_a("inflight_r1", 1);
        drv_a(0, 0, 0, 0, 0, 0, 0, 0);
        tick_a("idle", 2);
        tick_a("idle", 2);

        // DUT B: MAX_BURST=1, both writing continuously -> strict alternation
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            b0_v = (n0 < 4); b0_we = 1; b0_ad = 9'h100; b0_wd = b0_data[n0 % 4];
            b1_v = (n1 < 4); b1_we = 1; b1_ad = 9'(9'h180 + n1); b1_wd = 8'(8'h50 + n1);
            @(negedge clk);
            chk("b_grant", b0_rdy ? 0 : (b1_rdy ? 1 : 2), k % 2);
            chk("b_one_ready", int'(b0_rdy && b1_rdy), 0);
            if (b0_rdy) n0++;
            if (b1_rdy) n1++;
            @(posedge clk); #1;
        end
        b0_v = 0; b1_v = 0;
        @(posedge clk); #1;
        chk("b_mem_100", int'(mem_b[9'h100]), 8'h44);
        for (int i = 0; i < 4; i++)
            chk("b_mem_18x", int'(mem_b[9'h180 + i]), 8'h50 + i);

        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
